// File: rtl/circular_shift_right_seq.sv
`default_nettype none
// =============================================================================
// Module   : circular_shift_right_seq
// Brief    : Sequential rotate-right unit that rotates by one bit per clock,
//            then presents the result with a single-cycle done pulse.
// Revision : 1.0 - initial release
// =============================================================================
module circular_shift_right_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    output logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_c;
    logic             r_done;
    logic [WIDTH-1:0] w_rot;

    assign w_rot = {r_d[0], r_d[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_d     <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_d   <= A;
                        r_cnt <= B;
                        // A zero rotation completes on the accepting edge itself.
                        if (B == '0) begin
                            r_c     <= A;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_d   <= w_rot;
                    r_cnt <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_c     <= w_rot;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign C    = r_c;
    assign done = r_done;
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
